tree_mult_pipe: RTL and testbench

Parametrised, fully pipelined array multiplier built on a binary adder tree. It has one register stage per tree level, valid/ready handshakes on both sides and optional signed operation. It is the next generation of the team's single-register adder-tree multiplier. It sits between an upstream operand producer and a downstream consumer that may apply backpressure, and it sustains one product per cycle.

---
 rtl/tree_mult_pkg.sv | 13 +
 rtl/tree_add_level.sv | 31 +++
 rtl/tree_mult_pipe.sv | 117 +++++++++++
 tb/tb_tree_mult_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_mult_pkg.sv
// tree_mult_pkg: shared sizing helpers and types for the pipelined adder-tree multiplier
package tree_mult_pkg;
    localparam int N_DEF = 8;
    localparam int N_MAX = 32;
    function automatic int tree_lvl(input int n);
        return $clog2(n);
    endfunction
    function automatic int tree_stages(input int n);
        return tree_lvl(n) + 2;
    endfunction
    localparam int STAGES = tree_stages(N_DEF);
    typedef logic [2*N_MAX-1:0] psum_max_t;
endpackage

// File: rtl/tree_add_level.sv
// tree_add_level: one registered adder-tree level; sums adjacent input pairs under a shared enable
//   clk, rst (async, active high), i_en (pipeline advance), i_valid / o_valid (stage valid),
//   i_d: 2*PAIRS words of W bits, o_sum: PAIRS registered sums (wrap modulo 2^W)
module tree_add_level
    import tree_mult_pkg::*;
#(
    parameter int W     = 16,
    parameter int PAIRS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_en,
    input  logic                       i_valid,
    input  logic [2*PAIRS-1:0][W-1:0]  i_d,
    output logic [PAIRS-1:0][W-1:0]    o_sum,
    output logic                       o_valid
);
    logic [PAIRS-1:0][W-1:0] r_sum;
    logic                    r_valid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            for (int p = 0; p < PAIRS; p++) r_sum[p] <= i_d[2*p] + i_d[2*p+1];
        end
    end
    assign o_sum   = r_sum;
    assign o_valid = r_valid;
endmodule

// File: rtl/tree_mult_pipe.sv
// tree_mult_pipe: fully pipelined N x N multiplier, partial products reduced by a registered binary adder tree
//   clk, rst (async, active high)
//   in_valid/in_ready, a, b, in_signed: operand handshake (in_signed travels with the operands)
//   out_valid/out_ready, P: 2N-bit product handshake
//   Latency LVL+2 registers; one global stall (in_ready = !out_valid || out_ready) freezes every stage.
//   Macro TREE_MULT_SIGNED_EN: when defined, in_signed selects two's-complement operation;
//   when undefined in_signed is ignored and only unsigned logic is built.
module tree_mult_pipe
    import tree_mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           in_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] P
);
    localparam int LVL = tree_lvl(N);
    localparam int W   = 2 * N;
    typedef logic [W-1:0] word_t;

    logic          w_adv;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_v0;
    word_t [N-1:0] w_pp;
    word_t [N-1:0] r_pp;
    word_t         w_a_ext;
    logic          r_v1;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

`ifdef TREE_MULT_SIGNED_EN
    logic r_sgn;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sgn <= 1'b0;
        else if (w_adv) r_sgn <= in_signed;
    end
`else
    logic w_unused_sgn;
    assign w_unused_sgn = in_signed;
`endif

    // Stage 0: operand capture; a non-accept cycle loads a bubble (valid low)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_v0 <= 1'b0;
        end else if (w_adv) begin
            r_a  <= a;
            r_b  <= b;
            r_v0 <= in_valid;
        end
    end

    // Partial products; in signed mode the MSB row carries weight -2^(N-1), hence the negation
    always_comb begin
`ifdef TREE_MULT_SIGNED_EN
        w_a_ext = r_sgn ? {{N{r_a[N-1]}}, r_a} : {{N{1'b0}}, r_a};
`else
        w_a_ext = {{N{1'b0}}, r_a};
`endif
        for (int i = 0; i < N; i++) w_pp[i] = (w_a_ext & {W{r_b[i]}}) << i;
`ifdef TREE_MULT_SIGNED_EN
        w_pp[N-1] = r_sgn ? -w_pp[N-1] : w_pp[N-1];
`endif
    end

    // Stage 1: partial-product register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pp <= '0;
            r_v1 <= 1'b0;
        end else if (w_adv) begin
            r_pp <= w_pp;
            r_v1 <= r_v0;
        end
    end

    // Stages 2..LVL+1: each tree level halves the word count
    for (genvar k = 1; k <= LVL; k++) begin : g_lvl
        word_t [(N>>k)-1:0] w_sum;
        logic               w_v;
        if (k == 1) begin : g_first
            tree_add_level #(.W(W), .PAIRS(N >> k)) u_lvl (
                .clk     (clk),
                .rst     (rst),
                .i_en    (w_adv),
                .i_valid (r_v1),
                .i_d     (r_pp),
                .o_sum   (w_sum),
                .o_valid (w_v)
            );
        end else begin : g_next
            tree_add_level #(.W(W), .PAIRS(N >> k)) u_lvl (
                .clk     (clk),
                .rst     (rst),
                .i_en    (w_adv),
                .i_valid (g_lvl[k-1].w_v),
                .i_d     (g_lvl[k-1].w_sum),
                .o_sum   (w_sum),
                .o_valid (w_v)
            );
        end
    end

    assign P         = g_lvl[LVL].w_sum[0];
    assign out_valid = g_lvl[LVL].w_v;
endmodule

// File: tb/tb_tree_mult_pipe.sv
// tb_tree_mult_pipe: randomized and directed checks of tree_mult_pipe against an arithmetic product model
module tb_tree_mult_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [15:0] P;

    int n_cmp = 0, n_err = 0, cyc = 0, stall_cnt = 0, sweeps_done = 0;
    logic        held = 1'b0;
    logic [15:0] p_hold = '0;
    logic [63:0] expq[$];
    logic [63:0] obs[$];
    int          obs_cyc[$];

    tree_mult_pipe #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P)
    );

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s, input int n);
        logic [63:0] m, ux, uy;
        longint      sx, sy;
        logic        sg;
        m  = (64'd1 << (2*n)) - 64'd1;
        ux = {32'd0, x};
        uy = {32'd0, y};
        sg = s;
`ifndef TREE_MULT_SIGNED_EN
        sg = 1'b0;
`endif
        if (sg) begin
            sx = $signed(ux << (64 - n)) >>> (64 - n);
            sy = $signed(uy << (64 - n)) >>> (64 - n);
            return 64'(sx * sy) & m;
        end
        return (ux * uy) & m;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            expq.delete();
            held = 1'b0;
            chk("reset_out_valid", out_valid, 0);
            chk("reset_p", P, 0);
        end else begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (held) begin
                chk("stall_p_stable", P, p_hold);
                chk("stall_valid_stable", out_valid, 1);
            end
            if (out_valid) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got P=%0h with nothing outstanding, expected out_valid=0", P);
                end else begin
                    chk("product", P, expq[0]);
                    if (out_ready) void'(expq.pop_front());
                end
                if (out_ready) begin
                    obs.push_back(P);
                    obs_cyc.push_back(cyc);
                end
            end
            if (out_valid && !out_ready) stall_cnt++;
            held   = out_valid && !out_ready;
            p_hold = P;
            if (in_valid && in_ready) expq.push_back(ref_mul(a, b, in_signed, 8));
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic s);
        int t;
        t = 0;
        a = x;
        b = y;
        in_signed = s;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready=%0d after %0d cycles, expected 1", in_ready, t);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lat(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
        send(x, y, 1'b0);
        in_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            chk($sformatf("latency_valid_edge%0d", j), out_valid, j == 4);
            if (j == 4) chk("latency_p", P, e);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int W = (g == 0) ? 4 : (g == 1) ? 16 : 32;
        logic           s_rst, s_iv, s_ir, s_sg, s_ov, s_or;
        logic [W-1:0]   s_a, s_b;
        logic [2*W-1:0] s_p;
        logic [63:0]    q[$];
        logic [63:0]    first_p = '0;
        int             got = 0;

        tree_mult_pipe #(.N(W)) u_dut (
            .clk       (clk),
            .rst       (s_rst),
            .in_valid  (s_iv),
            .in_ready  (s_ir),
            .a         (s_a),
            .b         (s_b),
            .in_signed (s_sg),
            .out_valid (s_ov),
            .out_ready (s_or),
            .P         (s_p)
        );

        initial begin
            s_or = 1'b1;
            forever begin
                @(posedge clk);
                #1 s_or = ($urandom_range(3) != 0);
            end
        end

        always @(negedge clk) begin
            if (!s_rst) begin
                if (s_ov && s_or) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sweep%0d_unexpected: got P=%0h with nothing outstanding, expected none", W, s_p);
                    end else begin
                        chk($sformatf("sweep%0d_product", W), s_p, q.pop_front());
                        if (got == 0) first_p = s_p;
                        got++;
                    end
                end
                if (s_iv && s_ir) q.push_back(ref_mul(s_a, s_b, s_sg, W));
            end
        end

        initial begin
            s_rst = 1'b0;
            s_iv  = 1'b0;
            s_a   = '0;
            s_b   = '0;
            s_sg  = 1'b0;
            #1 s_rst = 1'b1;
            repeat (3) @(posedge clk);
            #1 s_rst = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                int t;
                t = 0;
                s_a  = (i == 0) ? '1 : W'($urandom);
                s_b  = (i == 0) ? '1 : W'($urandom);
                s_sg = (i == 0) ? 1'b0 : 1'($urandom);
                s_iv = 1'b1;
                do begin
                    @(negedge clk);
                    t++;
                end while (!s_ir && t < 200);
                if (!s_ir) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sweep%0d_send_timeout: in_ready=%0d, expected 1", W, s_ir);
                end
                @(posedge clk);
                #1;
            end
            s_iv = 1'b0;
            begin
                int t;
                t = 0;
                while (got < 1000 && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
            end
            chk($sformatf("sweep%0d_count", W), got, 1000);
            sweeps_done++;
        end
    end

    initial begin
        int gaps, t;
        rst = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid_lit", out_valid, 0);
        chk("reset_p_lit", P, 0);
        rst = 1'b0;
        sync();

        lat(8'h0D, 8'h0B, 16'h008F);

        sync();
        obs.delete();
        obs_cyc.delete();
        send(8'h80, 8'h80, 1'b1);
        send(8'hFF, 8'h01, 1'b1);
        send(8'h7F, 8'h80, 1'b1);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("corner_count", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("corner_80x80", obs[0], 64'h4000);
`ifdef TREE_MULT_SIGNED_EN
            chk("corner_FFx01", obs[1], 64'hFFFF);
            chk("corner_7Fx80", obs[2], 64'hC080);
`else
            chk("corner_FFx01", obs[1], 64'h00FF);
            chk("corner_7Fx80", obs[2], 64'h3F80);
`endif
            chk("corner_back_to_back", obs_cyc[2] - obs_cyc[0], 2);
        end

        sync();
        obs.delete();
        obs_cyc.delete();
        stall_cnt = 0;
        fork
            for (int i = 0; i < 10; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("bp_count", obs.size(), 10);
        chk("bp_stall_cycles", stall_cnt, 3);

        sync();
        obs.delete();
        obs_cyc.delete();
        for (int i = 0; i < 25; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("stream_count", obs.size(), 25);
        gaps = 0;
        for (int i = 1; i < obs_cyc.size(); i++) if (obs_cyc[i] != obs_cyc[i-1] + 1) gaps++;
        chk("stream_gaps", gaps, 0);

        sync();
        obs.delete();
        obs_cyc.delete();
        for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_p", P, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_no_stale", obs.size(), 0);
        sync();
        lat(8'hA5, 8'h3C, 16'h26AC);

        t = 0;
        while (sweeps_done < 3 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("sweeps_done", sweeps_done, 3);
        chk("sq32_unsigned", sw[2].first_p, 64'hFFFFFFFE00000001);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
